// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns fetch PC, issues one-outstanding word fetches, fills IF/ID.
// Zero-wait memory: instr on id_* 2 cycles after imem_req; decode stall parks a response in a 1-entry skid (HOLD).
module fetch_stage #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             stall,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [INS_W-1:0] imem_rdata,
   output logic [PC_W-1:0]  id_pc,
   output logic [INS_W-1:0] id_instr,
   output logic             id_valid
);

   localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

   typedef enum logic [1:0] {HOLD, REQ, WAIT, KILL} state_t;

   state_t           state;
   logic [PC_W-1:0]  fetch_pc;
   logic [PC_W-1:0]  req_pc;
   logic [PC_W-1:0]  skid_pc;
   logic [INS_W-1:0] skid_instr;
   logic             skid_full;

   logic [PC_W-1:0]  br_target;
   logic             id_load;
   logic             resp_acc;
   logic             resp_to_skid;
   logic             skid_drain;
   logic             skid_full_nxt;
   logic             unused_br;

   assign br_target = {BrPC[PC_W-1:2], 2'b00};
   assign unused_br = ^{BrPC[31:PC_W], BrPC[1:0]};

   assign imem_req  = (state == REQ);
   assign imem_addr = fetch_pc;

   // A redirect kills any response arriving in the same cycle.
   assign id_load      = (!stall || !id_valid) && !PcSel;
   assign resp_acc     = (state == WAIT) && imem_rvalid && !PcSel;
   assign skid_drain   = id_load && skid_full;
   assign resp_to_skid = resp_acc && (!id_load || skid_full);

   always_comb begin
      skid_full_nxt = 1'b0;
      if (!PcSel)
         skid_full_nxt = (skid_full && !id_load) || resp_to_skid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HOLD;
         fetch_pc   <= '0;
         req_pc     <= '0;
         skid_full  <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
         id_valid   <= 1'b0;
         id_pc      <= '0;
         id_instr   <= NOP;
      end else begin
         // IF/ID register: skid entry is older than any live response
         if (PcSel) begin
            id_valid <= 1'b0;
         end else if (id_load) begin
            if (skid_full) begin
               id_pc    <= skid_pc;
               id_instr <= skid_instr;
               id_valid <= 1'b1;
            end else if (resp_acc) begin
               id_pc    <= req_pc;
               id_instr <= imem_rdata;
               id_valid <= 1'b1;
            end else begin
               id_valid <= 1'b0;
            end
         end

         skid_full <= skid_full_nxt;
         if (resp_to_skid) begin
            skid_pc    <= req_pc;
            skid_instr <= imem_rdata;
         end

         case (state)
            REQ: begin
               if (imem_gnt) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= PcSel ? br_target : fetch_pc + PC_W'(4);
                  state    <= PcSel ? KILL : WAIT;
               end else if (PcSel) begin
                  fetch_pc <= br_target;
               end
            end
            WAIT: begin
               if (PcSel) begin
                  fetch_pc <= br_target;
                  state    <= imem_rvalid ? REQ : KILL;
               end else if (imem_rvalid) begin
                  state <= skid_full_nxt ? HOLD : REQ;
               end
            end
            KILL: begin
               // The in-flight response belongs to the squashed path.
               if (PcSel)
                  fetch_pc <= br_target;
               if (imem_rvalid)
                  state <= REQ;
            end
            HOLD: begin
               if (PcSel) begin
                  fetch_pc <= br_target;
                  state    <= REQ;
               end else if (!skid_full || skid_drain) begin
                  state <= REQ;
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage: memory handshakes driven per cycle, id_*/imem_* compared per cycle.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        PcSel;
   logic [31:0] BrPC;
   logic        stall;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [8:0]  id_pc;
   logic [31:0] id_instr;
   logic        id_valid;

   int checks   = 0;
   int failures = 0;

   fetch_stage #(.PC_W(9), .INS_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .PcSel       (PcSel),
      .BrPC        (BrPC),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_pc       (id_pc),
      .id_instr    (id_instr),
      .id_valid    (id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pcsel;
      logic [31:0] brpc;
      logic        stall;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [8:0]  e_addr;
      logic        e_valid;
      logic [8:0]  e_pc;
      logic [31:0] e_instr;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic pcsel, input logic [31:0] brpc, input logic stl,
                               input logic gnt, input logic rv, input logic [31:0] rdata,
                               input logic e_req, input logic [8:0] e_addr, input logic e_valid,
                               input logic [8:0] e_pc, input logic [31:0] e_instr);
      vec_t v;
      v.pcsel = pcsel; v.brpc = brpc; v.stall = stl; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
      end
   endtask

   task automatic chk_outs(input int row, input logic e_req, input logic [8:0] e_addr,
                           input logic e_valid, input logic [8:0] e_pc, input logic [31:0] e_instr);
      chk("imem_req",  row, 32'(imem_req),  32'(e_req));
      chk("imem_addr", row, 32'(imem_addr), 32'(e_addr));
      chk("id_valid",  row, 32'(id_valid),  32'(e_valid));
      chk("id_pc",     row, 32'(id_pc),     32'(e_pc));
      chk("id_instr",  row, id_instr,       e_instr);
   endtask

   task automatic drive(input logic pcsel, input logic [31:0] brpc, input logic stl,
                        input logic gnt, input logic rv, input logic [31:0] rdata);
      PcSel = pcsel; BrPC = brpc; stall = stl; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] ins(input logic [8:0] a);
      return 32'hA000_0000 | 32'(a);
   endfunction

   initial begin
      //                 pcsel brpc        stl gnt rv rdata            | req addr   vld pc     instr
      vecs[0]  = mk(0, 32'h0,   0, 0, 0, 32'h0,          0, 9'h000, 0, 9'h000, NOP);
      vecs[1]  = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h000, 0, 9'h000, NOP);
      vecs[2]  = mk(0, 32'h0,   0, 0, 1, ins(9'h000),    0, 9'h004, 0, 9'h000, NOP);
      vecs[3]  = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h004, 1, 9'h000, ins(9'h000));
      vecs[4]  = mk(0, 32'h0,   0, 0, 1, ins(9'h004),    0, 9'h008, 0, 9'h000, ins(9'h000));
      vecs[5]  = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h008, 1, 9'h004, ins(9'h004));
      vecs[6]  = mk(0, 32'h0,   0, 0, 1, ins(9'h008),    0, 9'h00C, 0, 9'h004, ins(9'h004));
      vecs[7]  = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h00C, 1, 9'h008, ins(9'h008));
      // response delayed three cycles after grant
      vecs[8]  = mk(0, 32'h0,   0, 0, 0, 32'h0,          0, 9'h010, 0, 9'h008, ins(9'h008));
      vecs[9]  = mk(0, 32'h0,   0, 0, 0, 32'h0,          0, 9'h010, 0, 9'h008, ins(9'h008));
      vecs[10] = mk(0, 32'h0,   0, 0, 1, ins(9'h00C),    0, 9'h010, 0, 9'h008, ins(9'h008));
      vecs[11] = mk(0, 32'h0,   0, 0, 0, 32'h0,          1, 9'h010, 1, 9'h00C, ins(9'h00C));
      vecs[12] = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h010, 0, 9'h00C, ins(9'h00C));
      vecs[13] = mk(0, 32'h0,   0, 0, 1, ins(9'h010),    0, 9'h014, 0, 9'h00C, ins(9'h00C));
      // stall for four cycles while a response lands in the skid
      vecs[14] = mk(0, 32'h0,   1, 1, 0, 32'h0,          1, 9'h014, 1, 9'h010, ins(9'h010));
      vecs[15] = mk(0, 32'h0,   1, 0, 1, ins(9'h014),    0, 9'h018, 1, 9'h010, ins(9'h010));
      vecs[16] = mk(0, 32'h0,   1, 0, 0, 32'h0,          0, 9'h018, 1, 9'h010, ins(9'h010));
      vecs[17] = mk(0, 32'h0,   1, 0, 0, 32'h0,          0, 9'h018, 1, 9'h010, ins(9'h010));
      vecs[18] = mk(0, 32'h0,   0, 0, 0, 32'h0,          0, 9'h018, 1, 9'h010, ins(9'h010));
      vecs[19] = mk(0, 32'h0,   1, 0, 0, 32'h0,          1, 9'h018, 1, 9'h014, ins(9'h014));
      vecs[20] = mk(0, 32'h0,   1, 1, 0, 32'h0,          1, 9'h018, 1, 9'h014, ins(9'h014));
      // redirect in WAIT, then a late response that must be discarded
      vecs[21] = mk(1, 32'h123, 1, 0, 0, 32'h0,          0, 9'h01C, 1, 9'h014, ins(9'h014));
      vecs[22] = mk(0, 32'h0,   0, 0, 1, 32'hDEAD_BEEF,  0, 9'h120, 0, 9'h014, ins(9'h014));
      vecs[23] = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h120, 0, 9'h014, ins(9'h014));
      vecs[24] = mk(0, 32'h0,   0, 0, 1, ins(9'h120),    0, 9'h124, 0, 9'h014, ins(9'h014));
      // redirect with stall and a full skid, target at top of address space
      vecs[25] = mk(0, 32'h0,   1, 1, 0, 32'h0,          1, 9'h124, 1, 9'h120, ins(9'h120));
      vecs[26] = mk(0, 32'h0,   1, 0, 1, ins(9'h124),    0, 9'h128, 1, 9'h120, ins(9'h120));
      vecs[27] = mk(1, 32'h1FC, 1, 0, 0, 32'h0,          0, 9'h128, 1, 9'h120, ins(9'h120));
      vecs[28] = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h1FC, 0, 9'h120, ins(9'h120));
      vecs[29] = mk(0, 32'h0,   0, 0, 1, ins(9'h1FC),    0, 9'h000, 0, 9'h120, ins(9'h120));
      vecs[30] = mk(0, 32'h0,   0, 1, 0, 32'h0,          1, 9'h000, 1, 9'h1FC, ins(9'h1FC));
      vecs[31] = mk(0, 32'h0,   0, 0, 0, 32'h0,          0, 9'h004, 0, 9'h1FC, ins(9'h1FC));

      reset = 1'b0;
      drive(0, 32'h0, 0, 0, 0, 32'h0);
      repeat (2) @(negedge clk);
      chk_outs(-1, 0, 9'h000, 0, 9'h000, NOP);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         chk_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
         drive(vecs[i].pcsel, vecs[i].brpc, vecs[i].stall, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
         @(negedge clk);
      end

      // still in WAIT for the request to 0x000: async reset mid-cycle
      drive(0, 32'h0, 0, 0, 0, 32'h0);
      chk_outs(100, 0, 9'h004, 0, 9'h1FC, ins(9'h1FC));
      #2 reset = 1'b0;
      #1 chk_outs(101, 0, 9'h000, 0, 9'h000, NOP);
      @(negedge clk);
      reset = 1'b1;
      chk_outs(102, 0, 9'h000, 0, 9'h000, NOP);
      @(negedge clk);
      chk_outs(103, 1, 9'h000, 0, 9'h000, NOP);
      drive(0, 32'h0, 0, 1, 0, 32'h0);
      @(negedge clk);
      chk_outs(104, 0, 9'h004, 0, 9'h000, NOP);
      drive(0, 32'h0, 0, 0, 1, 32'h1234_5678);
      @(negedge clk);
      chk_outs(105, 1, 9'h004, 1, 9'h000, 32'h1234_5678);
      drive(0, 32'h0, 0, 0, 0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
